// File: rtl/lcd_bus_tx.sv
// lcd_bus_tx: FIFO-buffered 8080-style parallel write engine.
// Queues {dcx, byte} requests, then drives dcx/D/wr with a
// SETUP -> STROBE (wr low) -> HOLD (wr high) cycle per byte.
module lcd_bus_tx #(
    parameter int DEPTH   = 4,  // FIFO entries, power of two, >= 2
    parameter int WR_LOW  = 2,  // cycles wr held low, >= 1
    parameter int WR_HIGH = 2   // cycles D/dcx held after wr rises, >= 1
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_dcx,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       dcx,
    output logic       wr,
    output logic [7:0] D,
    output logic       idle
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int TMAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count, count_n;
    logic            full, push, pop;
    logic [8:0]      head;

    state_t          state, state_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic            wr_n, dcx_n, idle_n;
    logic [7:0]      d_n;

    // No bypass: a full FIFO refuses input even when popping this cycle.
    assign full     = (count == CNTW'(DEPTH));
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    // FIFO storage; contents need no reset since pointers/count are flushed.
    always_ff @(posedge hwclk) begin
        if (push)
            mem[wr_ptr] <= {in_dcx, in_data};
    end

    // Next-state, pop decision and next values of the registered bus pins.
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        pop     = 1'b0;
        wr_n    = wr;
        dcx_n   = dcx;
        d_n     = D;
        case (state)
            IDLE: begin
                wr_n = 1'b1;
                if (count != '0) begin
                    pop          = 1'b1;
                    {dcx_n, d_n} = head;
                    state_n      = SETUP;
                end
            end
            SETUP: begin
                wr_n    = 1'b0;
                tmr_n   = TW'(WR_LOW - 1);
                state_n = STROBE;
            end
            STROBE: begin
                wr_n = 1'b0;
                if (tmr == '0) begin
                    wr_n    = 1'b1;
                    tmr_n   = TW'(WR_HIGH - 1);
                    state_n = HOLD;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            HOLD: begin
                wr_n = 1'b1;
                if (tmr == '0) begin
                    if (count != '0) begin
                        pop          = 1'b1;
                        {dcx_n, d_n} = head;
                        state_n      = SETUP;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            default: begin
                wr_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
        count_n = count + CNTW'(push) - CNTW'(pop);
        idle_n  = (state_n == IDLE) && (count_n == '0);
    end

    // State, timer, FIFO bookkeeping and registered outputs; rst aborts any byte.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state  <= IDLE;
            tmr    <= '0;
            wr     <= 1'b1;
            dcx    <= 1'b0;
            D      <= 8'h00;
            idle   <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
            wr    <= wr_n;
            dcx   <= dcx_n;
            D     <= d_n;
            idle  <= idle_n;
            count <= count_n;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_bus_tx.sv
// Directed bench for lcd_bus_tx: default timing instance plus a
// WR_LOW=1/WR_HIGH=3 instance; wr rising edges are logged for ordering.
module tb_lcd_bus_tx;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic       in_valid, in_dcx;
    logic [7:0] in_data;
    logic       in_ready1, dcx1, wr1, idle1;
    logic [7:0] d1;
    logic       in_valid2, in_dcx2;
    logic [7:0] in_data2;
    logic       in_ready2, dcx2, wr2, idle2;
    logic [7:0] d2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    lcd_bus_tx u_dut (
        .hwclk(tb_clk), .rst(rst), .in_valid(in_valid), .in_dcx(in_dcx),
        .in_data(in_data), .in_ready(in_ready1), .dcx(dcx1), .wr(wr1),
        .D(d1), .idle(idle1)
    );

    lcd_bus_tx #(.DEPTH(4), .WR_LOW(1), .WR_HIGH(3)) u_dut2 (
        .hwclk(tb_clk), .rst(rst), .in_valid(in_valid2), .in_dcx(in_dcx2),
        .in_data(in_data2), .in_ready(in_ready2), .dcx(dcx2), .wr(wr2),
        .D(d2), .idle(idle2)
    );

    always #5 tb_clk = ~tb_clk;

    always @(posedge tb_clk) cyc <= cyc + 1;

    // Log every wr rising edge of the default instance and flag bus changes while wr=0.
    logic       prev_wr = 1'b1;
    logic [8:0] prev_bus = 9'h000;
    int         dviol = 0;
    logic [8:0] rise_d[$];
    int         rise_cyc[$];
    always @(negedge tb_clk) begin
        if (prev_wr === 1'b0 && wr1 === 1'b1) begin
            rise_d.push_back({dcx1, d1});
            rise_cyc.push_back(cyc);
        end
        if (prev_wr === 1'b0 && wr1 === 1'b0 && {dcx1, d1} !== prev_bus)
            dviol <= dviol + 1;
        prev_wr  <= wr1;
        prev_bus <= {dcx1, d1};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // Present a byte, wait (bounded) for in_ready, then let the accepting edge pass.
    task automatic push(input logic dx, input logic [7:0] d, output int acc);
        int n = 0;
        in_valid = 1'b1;
        in_dcx   = dx;
        in_data  = d;
        while (!in_ready1 && n < 40) begin
            step();
            n++;
        end
        chk("push_wait", 32'(n < 40), 32'd1);
        step();
        acc = cyc;
    endtask

    task automatic wait_idle1();
        int n = 0;
        while (idle1 !== 1'b1 && n < 80) begin
            step();
            n++;
        end
        chk("idle1_reached", 32'(idle1), 32'd1);
    endtask

    initial begin
        int acc[6];
        int base;
        int n;
        logic [8:0] bexp[5];
        logic [8:0] fexp[6];
        int fdel[6];
        bexp = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F};
        fexp = '{9'h010, 9'h111, 9'h012, 9'h113, 9'h014, 9'h115};
        fdel = '{0, 1, 2, 3, 4, 7};

        rst = 1'b1; in_valid = 1'b0; in_dcx = 1'b0; in_data = 8'h00;
        in_valid2 = 1'b0; in_dcx2 = 1'b0; in_data2 = 8'h00;

        // Reset state
        step();
        chk("rst_in_ready", 32'(in_ready1), 32'd0);
        step();
        chk("rst_wr", 32'(wr1), 32'd1);
        chk("rst_d", 32'(d1), 32'h00);
        chk("rst_dcx", 32'(dcx1), 32'd0);
        chk("rst_idle", 32'(idle1), 32'd1);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready1), 32'd1);

        // Single write 2C as a command
        base = rise_d.size();
        push(1'b0, 8'h2C, acc[0]);
        in_valid = 1'b0;
        chk("single_idle_drop", 32'(idle1), 32'd0);
        step();
        chk("single_d", 32'(d1), 32'h2C);
        chk("single_dcx", 32'(dcx1), 32'd0);
        chk("single_setup_wr", 32'(wr1), 32'd1);
        step();
        chk("single_wr_low1", 32'(wr1), 32'd0);
        step();
        chk("single_wr_low2", 32'(wr1), 32'd0);
        step();
        chk("single_wr_rise", 32'(wr1), 32'd1);
        step();
        chk("single_hold_idle", 32'(idle1), 32'd0);
        chk("single_hold_d", 32'(d1), 32'h2C);
        step();
        chk("single_idle", 32'(idle1), 32'd1);
        chk("single_rises", 32'(rise_d.size() - base), 32'd1);

        // Burst of five back-to-back
        base = rise_d.size();
        for (int k = 0; k < 5; k++)
            push(bexp[k][8], bexp[k][7:0], acc[k]);
        in_valid = 1'b0;
        chk("burst_full", 32'(in_ready1), 32'd0);
        wait_idle1();
        chk("burst_rises", 32'(rise_d.size() - base), 32'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("burst_byte%0d", k), 32'(rise_d[base + k]), 32'(bexp[k]));
        for (int k = 1; k < 5; k++)
            chk($sformatf("burst_gap%0d", k), 32'(rise_cyc[base + k] - rise_cyc[base + k - 1]), 32'd5);

        // Full boundary: sixth byte waits for the first pop from full
        base = rise_d.size();
        for (int k = 0; k < 6; k++) begin
            if (k == 5)
                chk("full_ready_low", 32'(in_ready1), 32'd0);
            push(fexp[k][8], fexp[k][7:0], acc[k]);
        end
        in_valid = 1'b0;
        for (int k = 1; k < 6; k++)
            chk($sformatf("full_accept%0d", k), 32'(acc[k] - acc[0]), 32'(fdel[k]));
        wait_idle1();
        chk("full_rises", 32'(rise_d.size() - base), 32'd6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("full_byte%0d", k), 32'(rise_d[base + k]), 32'(fexp[k]));

        // Parameter sweep instance: WR_LOW=1, WR_HIGH=3
        in_valid2 = 1'b1; in_dcx2 = 1'b1; in_data2 = 8'h55;
        step();
        chk("sw_p0_wr", 32'(wr2), 32'd1);
        in_dcx2 = 1'b0; in_data2 = 8'hAA;
        step();
        in_valid2 = 1'b0;
        chk("sw_setup_d", 32'(d2), 32'h55);
        chk("sw_setup_dcx", 32'(dcx2), 32'd1);
        chk("sw_setup_wr", 32'(wr2), 32'd1);
        step();
        chk("sw_wr_low", 32'(wr2), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("sw_hold_wr%0d", k), 32'(wr2), 32'd1);
            chk($sformatf("sw_hold_d%0d", k), 32'(d2), 32'h55);
        end
        step();
        chk("sw_b2_d", 32'(d2), 32'hAA);
        chk("sw_b2_dcx", 32'(dcx2), 32'd0);
        chk("sw_b2_wr", 32'(wr2), 32'd1);
        step();
        chk("sw_b2_low", 32'(wr2), 32'd0);
        step();
        chk("sw_b2_rise", 32'(wr2), 32'd1);
        n = 0;
        while (idle2 !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("sw_idle", 32'(idle2), 32'd1);

        // Reset while wr is low, with bytes still queued
        push(1'b0, 8'h77, acc[0]);
        push(1'b1, 8'h88, acc[1]);
        push(1'b1, 8'h99, acc[2]);
        in_valid = 1'b0;
        chk("rs_strobe_wr", 32'(wr1), 32'd0);
        rst = 1'b1;
        #1;
        chk("rs_in_ready", 32'(in_ready1), 32'd0);
        step();
        chk("rs_wr", 32'(wr1), 32'd1);
        chk("rs_d", 32'(d1), 32'h00);
        chk("rs_dcx", 32'(dcx1), 32'd0);
        chk("rs_idle", 32'(idle1), 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk("rs_ready_after", 32'(in_ready1), 32'd1);
        base = rise_d.size();
        for (int k = 0; k < 10; k++)
            step();
        chk("rs_no_resume", 32'(rise_d.size() - base), 32'd0);
        chk("rs_still_idle", 32'(idle1), 32'd1);
        push(1'b1, 8'h5A, acc[0]);
        in_valid = 1'b0;
        step();
        chk("rs_new_d", 32'(d1), 32'h5A);
        chk("rs_new_dcx", 32'(dcx1), 32'd1);
        step();
        chk("rs_new_low", 32'(wr1), 32'd0);
        step();
        step();
        chk("rs_new_rise", 32'(wr1), 32'd1);
        wait_idle1();
        chk("rs_new_rises", 32'(rise_d.size() - base), 32'd1);
        chk("rs_new_byte", 32'(rise_d[base]), 32'h15A);

        chk("bus_stable_wr_low", 32'(dviol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
